mips_dmem_responder: RTL

Data-memory responder for the MIPS core: the memory-side end of the core's load/store interface. It accepts one word request at a time through a valid/ready handshake, inserts a fixed number of wait states, performs the read or byte-masked write on an internal word array, and returns exactly one response pulse per request. It sits between the core's MEM stage and the storage, and lets the bench exercise multi-cycle memory latency.

---
 rtl/mips_mem_pkg.sv | 24 ++
 rtl/mips_dmem_array.sv | 47 ++++
 rtl/mips_dmem_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_mem_pkg: shared types, constants and address check for dmem    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  // Illegal when not word aligned or when any bit above the array's byte span is set.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_dmem_array: word array, byte-enable write, registered read     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mips_dmem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic                  i_rd_clr,
  input  logic [ADDR_WIDTH-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  input  logic [WORD_BYTES-1:0] i_be,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (i_rd_en) begin
      r_rdata <= r_mem[i_idx];
    end else if (i_rd_clr) begin
      r_rdata <= 32'd0;
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mips_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_dmem_responder: valid/ready data-memory slave with wait states |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [WORD_BYTES-1:0] req_be,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam logic [3:0] c_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [WORD_BYTES-1:0] r_be;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_op_we;
  logic [31:0]           w_op_addr;
  logic [31:0]           w_op_wdata;
  logic [WORD_BYTES-1:0] w_op_be;
  logic                  w_op_err;
  logic [31:0]           w_rdata;

  assign w_accept     = (r_state == ST_IDLE) && req_valid && !rst;
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == 4'd0));

  // With no wait states the access happens on the accept edge, before the latches load.
  assign w_op_we    = (r_state == ST_IDLE) ? req_we    : r_we;
  assign w_op_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_op_be    = (r_state == ST_IDLE) ? req_be    : r_be;
  assign w_op_err   = addr_err(w_op_addr, ADDR_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: req_ready  = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_cnt   <= c_CNT_INIT;
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_err <= 1'b0;
    else if (w_enter_resp) r_err <= w_op_err;
  end

  mips_dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_enter_resp && !w_op_err && w_op_we),
    .i_rd_en  (w_enter_resp && !w_op_err && !w_op_we),
    .i_rd_clr (w_enter_resp && (w_op_err || w_op_we)),
    .i_idx    (w_op_addr[ADDR_WIDTH+1:2]),
    .i_wdata  (w_op_wdata),
    .i_be     (w_op_be),
    .o_rdata  (w_rdata)
  );

  assign resp_rdata = w_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire
